// File: rtl/prbs_run_sequencer.sv
// rtl/prbs_run_sequencer.sv - PRBS generator run-control FSM (optional error injection: PRBS_SEQ_ERR_INJ_EN)
module prbs_run_sequencer #(
    parameter int SEED_CYC = 4,
    parameter int N_RUN    = 32,
    parameter int N_ERR    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [N_RUN-1:0] run_len,
    input  logic [N_ERR-1:0] err_period,
    output logic             prbs_rst,
    output logic             prbs_cke,
    output logic             prbs_inj_err,
    output logic             busy,
    output logic             done,
    output logic [N_RUN-1:0] run_count,
    output logic [N_ERR-1:0] inj_count
);

    localparam int SW = (SEED_CYC > 1) ? $clog2(SEED_CYC) : 1;
    localparam logic [SW-1:0] SEED_LAST = SW'(SEED_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SW-1:0]    seed_cnt;
    logic [N_RUN-1:0] run_len_q;
    logic             run_start;
    logic             run_last;

    // A run is accepted only from IDLE and only when no stop is pending.
    assign run_start = (state == S_IDLE) && start && !stop;

    // Last RUN cycle: this cycle's increment makes run_count reach the latched length.
    assign run_last = (run_len_q != '0) && ((run_count + N_RUN'(1)) == run_len_q);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run_start) begin
                    state_nxt = S_SEED;
                end
            end
            S_SEED: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (seed_cnt == SEED_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop || run_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; control outputs are registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            prbs_rst <= 1'b1;
            prbs_cke <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            prbs_rst <= (state_nxt == S_SEED);
            prbs_cke <= (state_nxt == S_SEED) || (state_nxt == S_RUN);
            busy     <= (state_nxt == S_SEED) || (state_nxt == S_RUN);
            done     <= (state_nxt == S_DONE);
        end
    end

    // Seed-phase timer, latched run length and RUN-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_cnt  <= '0;
            run_len_q <= '0;
            run_count <= '0;
        end else begin
            if (run_start) begin
                seed_cnt  <= '0;
                run_len_q <= run_len;
                run_count <= '0;
            end else if (state == S_SEED) begin
                seed_cnt <= seed_cnt + SW'(1);
            end
            if (state == S_RUN) begin
                run_count <= run_count + N_RUN'(1);
            end
        end
    end

`ifdef PRBS_SEQ_ERR_INJ_EN
    logic [N_ERR-1:0] err_period_q;
    logic [N_ERR-1:0] per_cnt;
    logic [N_ERR-1:0] per_pos;
    logic             inj_hit;

    // Position within the injection period of the upcoming RUN cycle; restarts at 1
    // on entry to RUN and after every injection.
    always_comb begin
        per_pos = ((state == S_RUN) ? per_cnt : '0) + N_ERR'(1);
        inj_hit = (state_nxt == S_RUN) && (err_period_q != '0) && (per_pos == err_period_q);
    end

    // Period counter, injection pulse and saturating injection count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_period_q <= '0;
            per_cnt      <= '0;
            prbs_inj_err <= 1'b0;
            inj_count    <= '0;
        end else begin
            prbs_inj_err <= inj_hit;
            if (run_start) begin
                err_period_q <= err_period;
                inj_count    <= '0;
            end else if (inj_hit && (inj_count != '1)) begin
                inj_count <= inj_count + N_ERR'(1);
            end
            if ((state_nxt == S_RUN) && (err_period_q != '0) && !inj_hit) begin
                per_cnt <= per_pos;
            end else begin
                per_cnt <= '0;
            end
        end
    end
`else
    logic unused_err_period;

    assign unused_err_period = ^err_period;
    assign prbs_inj_err      = 1'b0;
    assign inj_count         = '0;
`endif

endmodule

// File: tb/tb_prbs_run_sequencer.sv
// tb/tb_prbs_run_sequencer.sv - directed self-checking bench for prbs_run_sequencer
module tb_prbs_run_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] run_len = '0;
    logic [15:0] err_period = '0;
    logic        prbs_rst, prbs_cke, prbs_inj_err, busy, done;
    logic [31:0] run_count;
    logic [15:0] inj_count;

    int errors = 0;
    int checks = 0;

`ifdef PRBS_SEQ_ERR_INJ_EN
    localparam bit INJ_EN = 1'b1;
`else
    localparam bit INJ_EN = 1'b0;
`endif

    prbs_run_sequencer #(.SEED_CYC(4), .N_RUN(32), .N_ERR(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .run_len(run_len), .err_period(err_period),
        .prbs_rst(prbs_rst), .prbs_cke(prbs_cke), .prbs_inj_err(prbs_inj_err),
        .busy(busy), .done(done), .run_count(run_count), .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    // Monitor sampled on the falling edge; cleared by mon_clr.
    logic mon_clr = 1'b0;
    int n_rst, n_cke, n_inj, n_done, n_inj_bad, run_idx, inj_pos0, inj_pos1;
    always @(negedge clk) begin
        if (mon_clr) begin
            n_rst = 0; n_cke = 0; n_inj = 0; n_done = 0; n_inj_bad = 0;
            run_idx = 0; inj_pos0 = 0; inj_pos1 = 0;
        end else begin
            if (prbs_rst) n_rst = n_rst + 1;
            if (prbs_cke) n_cke = n_cke + 1;
            if (done) n_done = n_done + 1;
            if (prbs_cke && !prbs_rst) run_idx = run_idx + 1;
            if (prbs_inj_err) begin
                if (!(prbs_cke && !prbs_rst)) n_inj_bad = n_inj_bad + 1;
                if (n_inj == 0) inj_pos0 = run_idx;
                if (n_inj == 1) inj_pos1 = run_idx;
                n_inj = n_inj + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic go(input logic [31:0] len, input logic [15:0] per);
        run_len = len;
        err_period = per;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
        tick();
    endtask

    initial begin
        // 1: reset
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_prbs_rst", 32'(prbs_rst), 32'd1);
        chk("rst_cke", 32'(prbs_cke), 32'd0);
        chk("rst_inj", 32'(prbs_inj_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_run_count", run_count, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_prbs_rst", 32'(prbs_rst), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // 2: basic run, run_len=10
        mon_reset();
        go(32'd10, 16'd0);
        chk("t2_seed_visible", 32'(prbs_rst), 32'd1);
        chk("t2_busy_visible", 32'(busy), 32'd1);
        wait_done("t2_done_seen");
        chk("t2_rst_cycles", 32'(n_rst), 32'd4);
        chk("t2_cke_cycles", 32'(n_cke), 32'd14);
        chk("t2_done_pulses", 32'(n_done), 32'd1);
        chk("t2_run_count", run_count, 32'd10);
        chk("t2_inj_count", 32'(inj_count), 32'd0);
        chk("t2_idle_after", 32'(busy), 32'd0);

        // 3: injection every 7 cycles over 20; config changed mid-run is ignored
        mon_reset();
        go(32'd20, 16'd7);
        run_len = 32'd3;
        err_period = 16'd2;
        wait_done("t3_done_seen");
        chk("t3_run_count", run_count, 32'd20);
        chk("t3_inj_pulses", 32'(n_inj), INJ_EN ? 32'd2 : 32'd0);
        chk("t3_inj_count", 32'(inj_count), INJ_EN ? 32'd2 : 32'd0);
        chk("t3_inj_pos0", 32'(inj_pos0), INJ_EN ? 32'd7 : 32'd0);
        chk("t3_inj_pos1", 32'(inj_pos1), INJ_EN ? 32'd14 : 32'd0);
        chk("t3_inj_outside_run", 32'(n_inj_bad), 32'd0);

        // 3b: err_period=1 injects on every RUN cycle
        mon_reset();
        go(32'd5, 16'd1);
        wait_done("t3b_done_seen");
        chk("t3b_inj_count", 32'(inj_count), INJ_EN ? 32'd5 : 32'd0);
        chk("t3b_inj_pulses", 32'(n_inj), INJ_EN ? 32'd5 : 32'd0);
        chk("t3b_inj_outside_run", 32'(n_inj_bad), 32'd0);

        // 4: free-run, stop in RUN cycle 25
        mon_reset();
        go(32'd0, 16'd0);
        for (int i = 0; i < 28; i++) tick();
        chk("t4_run_count_c25", run_count, 32'd24);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_run_count", run_count, 32'd25);
        chk("t4_cke_in_done", 32'(prbs_cke), 32'd0);
        tick();
        chk("t4_done_one_cycle", 32'(done), 32'd0);

        // 5: stop during SEED cycle 2, then start while running is ignored
        mon_reset();
        go(32'd10, 16'd0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_prbs_rst", 32'(prbs_rst), 32'd0);
        chk("t5_abort_run_count", run_count, 32'd0);
        tick();
        chk("t5_abort_no_done", 32'(n_done), 32'd0);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("t5_start_stop_idle", 32'(busy), 32'd0);
        go(32'd10, 16'd0);
        for (int i = 0; i < 6; i++) tick();
        go(32'd3, 16'd0);
        wait_done("t5_done_seen");
        chk("t5_run_count", run_count, 32'd10);
        chk("t5_done_pulses", 32'(n_done), 32'd1);

        // 6: reset in RUN cycle 5
        mon_reset();
        go(32'd10, 16'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("t6_run_count_c5", run_count, 32'd4);
        rst = 1'b1;
        tick();
        chk("t6_prbs_rst", 32'(prbs_rst), 32'd1);
        chk("t6_cke", 32'(prbs_cke), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_run_count", run_count, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("t6_no_done", 32'(n_done), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
